nsdp_run_ctl: RTL

Run-control sequencer for the NSDP checker datapath.
- Arms and disarms the packet checker.
- Counts received and malformed packets.
- Latches a single first-error snapshot (error bitmap, offending 64-byte beat, expected values) and freezes it until restart.
- Tracks Ethernet activity with a reloadable timeout.
- Sits between the checker core and the AXI register block, and drives that block's status/counter/snapshot inputs directly.

---
 rtl/nsdp_run_ctl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nsdp_run_ctl.sv
// Run-control sequencer: arms/disarms the checker, counts packets, freezes a first-error snapshot, tracks activity.
// Latency: every input event appears on the registered outputs exactly one clock later.
// Backpressure: none; the stream is only observed, and every pulse input is acted on in the cycle it is sampled.
module nsdp_run_ctl #(
  parameter int unsigned ACTIVITY_TIMEOUT = 100000000,
  parameter int unsigned TMR_W            = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear_counters,
  input  logic         pkt_valid,
  input  logic         pkt_last,
  input  logic         pkt_malformed,
  input  logic [31:0]  err_in,
  input  logic [511:0] err_data_in,
  input  logic [31:0]  exp_fdata_in,
  input  logic [63:0]  exp_taddr_in,
  input  logic [31:0]  exp_fc_in,
  input  logic [15:0]  exp_seq_in,
  output logic         checker_enable,
  output logic         run_status,
  output logic         eth_active,
  output logic [31:0]  error,
  output logic [511:0] error_data,
  output logic [31:0]  expected_fdata,
  output logic [63:0]  expected_taddr,
  output logic [31:0]  expected_fc,
  output logic [15:0]  expected_seq,
  output logic [63:0]  packets_rcvd,
  output logic [63:0]  malformed_packets
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             enter_run;   // start accepted: clear snapshot and counters
  logic             take_err;    // first error in RUN: latch snapshot
  logic             count_pkt;   // final beat seen while running
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  // Next-state decode; error beats stop in RUN, start beats stop elsewhere.
  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    take_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (err_in != 32'd0) begin
          state_d  = S_FAULT;
          take_err = 1'b1;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (start) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Packet qualification and activity-timer next value.
  always_comb begin
    count_pkt = (state_q == S_RUN) && pkt_valid && pkt_last;
    if (pkt_valid) begin
      timer_d = TMR_W'(ACTIVITY_TIMEOUT);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  // State register plus the run flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      checker_enable <= 1'b0;
      run_status     <= 1'b0;
    end else begin
      state_q        <= state_d;
      checker_enable <= (state_d == S_RUN);
      run_status     <= (state_d == S_RUN);
    end
  end

  // First-error snapshot: cleared on (re)arm, captured once, then frozen.
  always_ff @(posedge clk) begin
    if (reset || enter_run) begin
      error          <= '0;
      error_data     <= '0;
      expected_fdata <= '0;
      expected_taddr <= '0;
      expected_fc    <= '0;
      expected_seq   <= '0;
    end else if (take_err) begin
      error          <= err_in;
      error_data     <= err_data_in;
      expected_fdata <= exp_fdata_in;
      expected_taddr <= exp_taddr_in;
      expected_fc    <= exp_fc_in;
      expected_seq   <= exp_seq_in;
    end
  end

  // Saturating packet counters; any clear source wins over an increment.
  always_ff @(posedge clk) begin
    if (reset || enter_run || clear_counters) begin
      packets_rcvd      <= '0;
      malformed_packets <= '0;
    end else if (count_pkt) begin
      if (packets_rcvd != '1) begin
        packets_rcvd <= packets_rcvd + 64'd1;
      end
      if (pkt_malformed && (malformed_packets != '1)) begin
        malformed_packets <= malformed_packets + 64'd1;
      end
    end
  end

  // Activity timer; eth_active follows the new timer value so it rises one cycle after pkt_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      eth_active <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      eth_active <= (timer_d != '0);
    end
  end

endmodule
